uart_cmd_seq: RTL
=================

// Module: uart_cmd_seq
// PURPOSE
// Sequences the byte-wide UART receiver into 3-byte command frames: opcode, data[15:8], data[7:0].
// Accepts each received byte and clears the receiver's ready flag.
// Publishes a complete {cmd,data} word with a sticky ready flag.
// Discards partial frames after an inter-byte gap timeout.
// Sits between the UART receiver and the command dispatcher.
// PARAMETERS
// TIMEOUT_CLKS  31248  max clocks allowed between bytes of one frame (12 bit-times at 2604 clk/bit)
// TMR_W         15     width of gap timer; must satisfy 2**TMR_W > TIMEOUT_CLKS
// PORTS
// clk          in   1   system clock, all logic on posedge
// rst          in   1   asynchronous reset, active-high
// rx_rdy       in   1   receiver holds a complete byte
// rx_data      in   8   received byte, valid while rx_rdy=1
// rx_rdy_clr   out  1   one-cycle pulse, clears receiver's rx_rdy
// clr_cmd_rdy  in   1   dispatcher has consumed cmd/data
// cmd          out  8   opcode of last complete frame
// data         out  16  payload of last complete frame
// cmd_rdy      out  1   sticky: a new frame is in cmd/data
// timeout      out  1   one-cycle pulse: partial frame discarded
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, rx_rdy_clr=0, cmd=8'h00, data=16'h0000, cmd_rdy=0,
//   timeout=0, timer=0, holding regs=0.
// - Byte accept condition: rx_rdy & ~rx_rdy_clr.
//   - rx_rdy_clr is registered and high exactly the cycle after an accept.
//   - The receiver drops rx_rdy the cycle after that, so one byte is never accepted twice.
// - FSM states: IDLE, GET_HI, GET_LO.
//   - IDLE: accept -> opcode into hold_cmd, clear cmd_rdy, go GET_HI.
//   - GET_HI: accept -> hold_hi, go GET_LO.
//   - GET_LO: accept -> cmd<=hold_cmd, data<={hold_hi,rx_data}, cmd_rdy<=1, go IDLE.
//   - Latency: cmd/data/cmd_rdy update on the clock edge that accepts byte 3.
// - cmd/data change only on frame completion; partial frames never disturb them.
// - cmd_rdy is cleared by clr_cmd_rdy, or by accepting a new opcode byte in IDLE.
//   - Completion and clr_cmd_rdy in the same cycle: set wins, cmd_rdy=1.
//   - clr_cmd_rdy while cmd_rdy=0: no effect.
// - Gap timer: runs only in GET_HI/GET_LO. Zeroed on every accept and on entry to IDLE.
//   - Expiry: timer==TIMEOUT_CLKS-1 with no accept that cycle -> go IDLE, pulse timeout.
//   - On expiry, cmd/data/cmd_rdy are unchanged.
//   - Accept and expiry in the same cycle: the accept wins, no timeout.
// - IDLE has no timeout; the timer holds at 0.
// - Back-to-back frames need no idle gap; the byte after completion is a new opcode.
// - Reset asserted mid-frame: partial frame is lost, outputs go to reset values immediately.
// STRUCTURE
// - Package uart_cmd_pkg:
//   - typedef enum logic [1:0] {IDLE,GET_HI,GET_LO} cmd_state_t;
//   - localparam FRAME_BYTES=3;
//   - localparam BIT_CLKS=2604.
// - One sub-module, gap_timer:
//   - inputs clk, rst, clr, en; output expired; parameters TIMEOUT_CLKS, TMR_W.
// - The FSM, holding regs and output regs stay in uart_cmd_seq.
// - Bench pairs uart_cmd_seq with the existing UART_rcv driven by a serial byte task.
// TESTING
// 1. Frames A5,12,34 with 1-bit gaps -> cmd=A5, data=1234, cmd_rdy=1;
//    exactly 3 rx_rdy_clr pulses, timeout never fires.
// 2. Hold clr_cmd_rdy for 1 clk after test 1 -> cmd_rdy=0, cmd/data still A5/1234;
//    next opcode 0F starts a frame and cmd/data stay 1234 until byte 3.
// 3. Send 0F,AA, then idle 31248 clks -> timeout pulses once on the expiry clock;
//    state=IDLE; then 0F,BB,CC -> data=BBCC.
// 4. Byte 3 arrives on clock TIMEOUT_CLKS-1 (forced rx_rdy) -> frame completes, no timeout pulse.
// 5. Completion of frame 7E,00,01 in the same cycle as clr_cmd_rdy -> cmd_rdy=1, data=0001.
// 6. Assert rst after byte 2 of 55,66,77 -> all outputs 0 asynchronously;
//    after release, 11,22,33 -> cmd=11, data=2233.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared state encoding and timing constants for the UART command sequencer
package uart_cmd_pkg;
  typedef enum logic [1:0] {IDLE, GET_HI, GET_LO} cmd_state_t;
  localparam int FRAME_BYTES = 3;
  localparam int BIT_CLKS = 2604;
endpackage

// File: rtl/uart_cmd_seq_gap_timer.sv
// gap_timer: counts clocks between frame bytes while enabled and flags the last allowed clock
module gap_timer #(
  parameter int TIMEOUT_CLKS = 31248,
  parameter int TMR_W = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [TMR_W-1:0] tmr_q, tmr_d;
  assign expired = en & (tmr_q == TMR_W'(TIMEOUT_CLKS - 1));
  always_comb tmr_d = (clr | ~en) ? '0 : tmr_q + TMR_W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) tmr_q <= '0;
    else tmr_q <= tmr_d;
endmodule

// File: rtl/uart_cmd_seq.sv
// uart_cmd_seq: assembles opcode/data_hi/data_lo bytes from the UART receiver into command words
module uart_cmd_seq
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 12 * BIT_CLKS,
  parameter int TMR_W = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        rx_rdy_clr,
  input  logic        clr_cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  output logic        timeout
);
  cmd_state_t state_q, state_d;
  logic [7:0] hold_cmd_q, hold_cmd_d, hold_hi_q, hold_hi_d, cmd_q, cmd_d;
  logic [15:0] data_q, data_d;
  logic rx_rdy_clr_q, rx_rdy_clr_d, cmd_rdy_q, cmd_rdy_d, timeout_q, timeout_d;
  logic accept, expired;
  // the pending clear pulse masks rx_rdy so a byte is taken only once
  assign accept = rx_rdy & ~rx_rdy_clr_q;
  gap_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS), .TMR_W(TMR_W)) u_gap_timer (
    .clk(clk),
    .rst(rst),
    .clr(accept | expired),
    .en(state_q != IDLE),
    .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    hold_cmd_d = hold_cmd_q;
    hold_hi_d = hold_hi_q;
    cmd_d = cmd_q;
    data_d = data_q;
    cmd_rdy_d = cmd_rdy_q & ~clr_cmd_rdy;
    rx_rdy_clr_d = accept;
    timeout_d = expired & ~accept;
    if (accept)
      case (state_q)
        IDLE: begin
          hold_cmd_d = rx_data;
          cmd_rdy_d = 1'b0;
          state_d = GET_HI;
        end
        GET_HI: begin
          hold_hi_d = rx_data;
          state_d = GET_LO;
        end
        default: begin
          cmd_d = hold_cmd_q;
          data_d = {hold_hi_q, rx_data};
          cmd_rdy_d = 1'b1;
          state_d = IDLE;
        end
      endcase
    else if (expired) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      hold_cmd_q <= '0;
      hold_hi_q <= '0;
      cmd_q <= '0;
      data_q <= '0;
      cmd_rdy_q <= 1'b0;
      rx_rdy_clr_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_cmd_q <= hold_cmd_d;
      hold_hi_q <= hold_hi_d;
      cmd_q <= cmd_d;
      data_q <= data_d;
      cmd_rdy_q <= cmd_rdy_d;
      rx_rdy_clr_q <= rx_rdy_clr_d;
      timeout_q <= timeout_d;
    end
  assign rx_rdy_clr = rx_rdy_clr_q;
  assign cmd = cmd_q;
  assign data = data_q;
  assign cmd_rdy = cmd_rdy_q;
  assign timeout = timeout_q;
endmodule
